// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch front end.
//   RstEnable/RstDisable   : active level of the low-true reset input
//   ChipEnable/ChipDisable : ROM read-enable levels
//   InstAddrBus/InstBus    : default address / instruction word widths
//   ZeroWord               : all-zero instruction word
package if_prefetch_pkg;
  localparam logic RstEnable   = 1'b0;
  localparam logic RstDisable  = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = '0;
endpackage

// File: rtl/if_prefetch_fifo.sv
// inst_fifo: synchronous FIFO of {pc, inst} entries feeding decode.
//   clk, rst    : clock, async active-low reset
//   push/data   : write an entry at the end of the cycle
//   pop         : drop the head entry at the end of the cycle
//   flush       : empty the FIFO; wins over push and pop
//   count       : current occupancy (0..DEPTH)
//   head        : entry at the read pointer (undefined when count==0)
module inst_fifo
  import if_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok, push_ok;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: PC generation, ROM request issue and prefetch buffering for decode.
//   clk, rst        : clock, async active-low reset
//   rom_ce/rom_addr : one word-aligned read per cycle to a 1-cycle-latency ROM
//   rom_data        : ROM word, valid the cycle after rom_ce
//   id_valid/ready  : handshake toward decode, id_pc/id_inst from FIFO head
//   branch_flag/tgt : redirect; flushes buffered and in-flight words
//   fetch_misalign  : one-cycle pulse after a redirect to a non-word-aligned target
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrBus,
  parameter int                DATA_W   = InstBus,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              fetch_misalign
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int EW    = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] pc, req_pc;
  logic              inflight;
  logic              misalign_q;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occ;
  logic [EW-1:0]     head;
  logic              issue, push, pop;

  // Reserve a slot for every outstanding request so a return always fits.
  assign occ   = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign issue = (rst == RstDisable) && !branch_flag && (occ < (CNT_W+1)'(DEPTH));

  assign rom_ce   = issue ? ChipEnable : ChipDisable;
  assign rom_addr = issue ? pc : '0;

  // A word returning during a redirect cycle belongs to the old stream.
  assign push = inflight && !branch_flag;
  assign pop  = id_valid && id_ready;

  assign id_valid       = (count != '0);
  assign id_pc          = id_valid ? head[EW-1:DATA_W] : '0;
  assign id_inst        = id_valid ? head[DATA_W-1:0] : DATA_W'(ZeroWord);
  assign fetch_misalign = misalign_q;

  inst_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({req_pc, rom_data}),
    .pop       (pop),
    .flush     (branch_flag),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      pc         <= {RESET_PC[ADDR_W-1:2], 2'b00};
      req_pc     <= '0;
      inflight   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      inflight   <= issue;
      misalign_q <= branch_flag && (branch_target[1:0] != 2'b00);
      if (issue) req_pc <= pc;
      if (branch_flag)
        pc <= {branch_target[ADDR_W-1:2], 2'b00};
      else if (issue)
        pc <= pc + ADDR_W'(4);
    end
  end
endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc, id_inst;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        fetch_misalign;

  int checks = 0;
  int failures = 0;

  if_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .branch_flag(branch_flag), .branch_target(branch_target), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  // ROM contents: word i holds value i.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) if (rom_ce) rom_data <= rom_word(rom_addr);

  // Reference model: a queue of fetched-but-unconsumed words plus the one
  // outstanding ROM request (if any).
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        q[$];
  bit          m_inf;
  logic [31:0] m_inf_pc, m_pc;
  bit          m_mis;

  logic        o_ce, o_valid, o_mis;
  logic [31:0] o_addr, o_pc, o_inst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    q.delete();
    m_inf = 0; m_inf_pc = '0; m_pc = '0; m_mis = 0;
  endtask

  // One clock cycle: drive, compare at negedge, advance the model at posedge.
  task automatic cycle(input bit rdy, input bit bf, input logic [31:0] tgt);
    bit          e_ce, e_valid, pop, push;
    logic [31:0] e_pc, e_inst;
    id_ready = rdy; branch_flag = bf; branch_target = tgt;
    @(negedge clk);
    e_ce    = rst && !bf && (q.size() + int'(m_inf) < DEPTH);
    e_valid = q.size() != 0;
    e_pc    = e_valid ? q[0].pc : 32'h0;
    e_inst  = e_valid ? q[0].inst : 32'h0;
    o_ce = rom_ce; o_addr = rom_addr; o_valid = id_valid;
    o_pc = id_pc; o_inst = id_inst; o_mis = fetch_misalign;
    chk("rom_ce", {31'b0, o_ce}, {31'b0, e_ce});
    chk("rom_addr", o_addr, e_ce ? m_pc : 32'h0);
    chk("id_valid", {31'b0, o_valid}, {31'b0, e_valid});
    chk("id_pc", o_pc, e_pc);
    chk("id_inst", o_inst, e_inst);
    chk("misalign", {31'b0, o_mis}, {31'b0, m_mis});
    @(posedge clk);
    if (rst) begin
      pop  = e_valid && rdy;
      push = m_inf && !bf;
      if (bf) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{pc: m_inf_pc, inst: rom_word(m_inf_pc)});
      end
      m_inf = e_ce; m_inf_pc = m_pc;
      if (bf) m_pc = {tgt[31:2], 2'b00};
      else if (e_ce) m_pc = m_pc + 32'd4;
      m_mis = bf && (tgt[1:0] != 2'b00);
    end
    #1;
  endtask

  initial begin
    logic [31:0] pc_hold;
    mreset();
    rst = 1'b0;
    #2;
    chk("reset_ce", {31'b0, rom_ce}, 32'h0);
    chk("reset_valid", {31'b0, id_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Straight-line fetch after reset release.
    cycle(1, 0, 0); chk("t1_addr0", o_addr, 32'h0);
    cycle(1, 0, 0); chk("t1_addr1", o_addr, 32'h4);
    cycle(1, 0, 0); chk("t1_first_valid", {31'b0, o_valid}, 32'h1);
                    chk("t1_first_pc", o_pc, 32'h0);
    cycle(1, 0, 0); chk("t1_second_inst", o_inst, 32'h1);

    // Stall: FIFO fills, issue stops, head is held.
    cycle(0, 0, 0); pc_hold = o_pc;
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0); chk("t2_head_hold", o_pc, pc_hold);
    end
    chk("t2_issue_stopped", {31'b0, o_ce}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0); chk("t2_drain_order", o_pc, pc_hold + 32'(4 * i));
    end

    // Redirect with buffered and in-flight words.
    cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(0, 1, 32'h100);
    cycle(1, 0, 0); chk("t3_b1_addr", o_addr, 32'h100);
                    chk("t3_b1_novalid", {31'b0, o_valid}, 32'h0);
    cycle(1, 0, 0); chk("t3_b2_novalid", {31'b0, o_valid}, 32'h0);
    cycle(1, 0, 0); chk("t3_b3_pc", o_pc, 32'h100);
    cycle(1, 0, 0); chk("t3_b4_pc", o_pc, 32'h104);

    // Misaligned redirect.
    cycle(1, 1, 32'h102);
    cycle(1, 0, 0); chk("t4_mis_pulse", {31'b0, o_mis}, 32'h1);
    cycle(1, 0, 0); chk("t4_mis_clear", {31'b0, o_mis}, 32'h0);
    cycle(1, 0, 0); chk("t4_pc", o_pc, 32'h100);

    // Reset mid-stream with a full FIFO.
    for (int i = 0; i < 8; i++) cycle(0, 0, 0);
    rst = 1'b0;
    #1;
    chk("t5_ce", {31'b0, rom_ce}, 32'h0);
    chk("t5_addr", rom_addr, 32'h0);
    chk("t5_valid", {31'b0, id_valid}, 32'h0);
    chk("t5_pc", id_pc, 32'h0);
    chk("t5_inst", id_inst, 32'h0);
    mreset();
    cycle(1, 0, 0);
    rst = 1'b1;
    cycle(1, 0, 0); chk("t5_restart_addr", o_addr, 32'h0);
    cycle(1, 0, 0);
    cycle(1, 0, 0); chk("t5_restart_pc", o_pc, 32'h0);

    // Address wrap and back-to-back redirects.
    cycle(1, 1, 32'hFFFF_FFFC);
    cycle(1, 0, 0); chk("t6_addr_top", o_addr, 32'hFFFF_FFFC);
    cycle(1, 0, 0); chk("t6_addr_wrap", o_addr, 32'h0);
    cycle(1, 1, 32'h200);
    cycle(1, 1, 32'h300); chk("t6_no_first_fetch", {31'b0, o_ce}, 32'h0);
    cycle(1, 0, 0); chk("t6_second_addr", o_addr, 32'h300);
    cycle(1, 0, 0);
    cycle(1, 0, 0); chk("t6_second_pc", o_pc, 32'h300);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(9, 0) < 7, $urandom_range(19, 0) == 0, $urandom());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
